pc_sequencer: RTL



---
 rtl/pc_pkg.sv | 27 ++
 rtl/ret_stack.sv | 72 +++++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encodings for the program-counter sequencer
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_SEQ  = 3'd0,
        PC_OP_REL  = 3'd1,
        PC_OP_ABS  = 3'd2,
        PC_OP_CALL = 3'd3,
        PC_OP_RET  = 3'd4
    } pc_op_e;

    // Reserved encodings fold onto SEQ so the control unit can never wedge the PC.
    function automatic pc_op_e pc_op_decode(input logic [PC_OP_W-1:0] raw);
        pc_op_e dec;
        case (raw)
            3'd1:    dec = PC_OP_REL;
            3'd2:    dec = PC_OP_ABS;
            3'd3:    dec = PC_OP_CALL;
            3'd4:    dec = PC_OP_RET;
            default: dec = PC_OP_SEQ;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - circular return-address LIFO with registered full/empty
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign top_ptr = wr_ptr_q - 1'b1;
    assign top     = mem_q[top_ptr];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

    // When full, wr_ptr already points at the oldest entry, so a push overwrites it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (!full_q) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && !empty_q) begin
            wr_ptr_d = top_ptr;
            count_d  = count_q - 1'b1;
        end
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register with next-PC select, return stack and sticky errors
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          INC         = 1,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic [PC_OP_W-1:0] op,
    input  logic [ADDR_W-1:0]  target,
    input  logic [ADDR_W-1:0]  offset,
    input  logic               err_clear,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_inc,
    output logic               stack_empty,
    output logic               stack_full,
    output logic               stack_ovf,
    output logic               stack_unf
);

    localparam logic [ADDR_W-1:0] INC_V   = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);
    localparam int                CNT_W   = $clog2(STACK_DEPTH) + 1;

    pc_op_e            op_dec;
    logic              do_call, do_ret, ret_hit, ret_miss;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stk_top;
    logic [CNT_W-1:0]  stk_count;
    logic              stk_full, stk_empty;

    assign pc_inc      = pc_q + INC_V;
    assign pc          = pc_q;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

    always_comb begin
        op_dec   = pc_op_decode(op);
        do_call  = !stall && (op_dec == PC_OP_CALL);
        do_ret   = !stall && (op_dec == PC_OP_RET);
        ret_hit  = do_ret && (stk_count != '0);
        ret_miss = do_ret && (stk_count == '0);
    end

    // REL is relative to the current pc, not the link value.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            case (op_dec)
                PC_OP_REL:  pc_d = pc_q + offset;
                PC_OP_ABS:  pc_d = target;
                PC_OP_CALL: pc_d = target;
                PC_OP_RET:  pc_d = ret_hit ? stk_top : pc_inc;
                default:    pc_d = pc_inc;
            endcase
        end
    end

    // A new error in the same cycle as err_clear keeps the flag set.
    always_comb begin
        ovf_d = (ovf_q && !err_clear) || (do_call && stk_full);
        unf_d = (unf_q && !err_clear) || ret_miss;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_V;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (do_call),
        .pop       (ret_hit),
        .push_data (pc_inc),
        .top       (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

endmodule
